ifu_fetch: RTL

Instruction fetch unit for the npc core. It owns the program counter and fetches one 32-bit instruction at a time from instruction memory over a request/grant/response handshake. Each fetched instruction is held with its PC until the downstream decode/execute stage accepts it, and the stage returns the next PC at that moment. It sits directly upstream of the core's decode/ALU/register-file datapath, replacing the combinational memory read.

---
 rtl/ifu_fetch.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/ifu_fetch.sv
// ============================================================================
// Module   : ifu_fetch
// Brief    : Instruction fetch unit. Owns the PC and fetches one 32-bit word
//            at a time over a req/gnt/rvalid handshake. Each word is held with
//            its PC until downstream consumes it and returns the next PC.
//            Optional macro IFU_TIMEOUT_EN adds a WAIT timeout, a terminal ERR
//            state and a sticky fetch_err flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module ifu_fetch #(
    parameter logic [31:0] RESET_PC = 32'h8000_0000,
    parameter logic [7:0]  TIMEOUT  = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    output logic        mem_req,
    output logic [31:0] mem_addr,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [31:0] mem_rdata,
    output logic        inst_valid,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    input  logic        inst_ready,
    input  logic [31:0] next_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        fetch_err
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_VALID = 3'd3
`ifdef IFU_TIMEOUT_EN
        , S_ERR = 3'd4
`endif
    } state_t;

    // PCs are word aligned, so only bits [31:2] are stored.
    state_t      state_q, state_d;
    logic [31:2] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:2] inst_pc_q, inst_pc_d;
    logic        kill_q, kill_d;

`ifdef IFU_TIMEOUT_EN
    logic [7:0]  cnt_q, cnt_d;
    logic        err_q, err_d;
    logic [7:0]  w_cnt_inc;
    assign w_cnt_inc = cnt_q + 8'd1;
`endif

    // Low PC bits are discarded by alignment; TIMEOUT only matters with the timeout option.
    logic w_unused;
    assign w_unused = ^{next_pc[1:0], redirect_pc[1:0], TIMEOUT};

    // State and datapath registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= S_IDLE;
            pc_q      <= RESET_PC[31:2];
            inst_q    <= 32'd0;
            inst_pc_q <= RESET_PC[31:2];
            kill_q    <= 1'b0;
`ifdef IFU_TIMEOUT_EN
            cnt_q     <= 8'd0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
            kill_q    <= kill_d;
`ifdef IFU_TIMEOUT_EN
            cnt_q     <= cnt_d;
            err_q     <= err_d;
`endif
        end
    end

    // Next-state logic; a redirect overrides every other event in the cycle.
    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        kill_d    = kill_q;
`ifdef IFU_TIMEOUT_EN
        cnt_d     = cnt_q;
        err_d     = err_q;
`endif
        case (state_q)
            S_IDLE: state_d = S_REQ;
            S_REQ: begin
                if (mem_gnt) begin
                    // A redirect alongside a grant leaves one stale response to discard.
                    state_d = S_WAIT;
                    kill_d  = redirect_valid;
`ifdef IFU_TIMEOUT_EN
                    cnt_d   = 8'd0;
`endif
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    if (mem_rvalid) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        kill_d  = 1'b1;
                    end
                end else if (mem_rvalid) begin
                    if (kill_q) begin
                        state_d = S_REQ;
                        kill_d  = 1'b0;
                    end else begin
                        inst_d    = mem_rdata;
                        inst_pc_d = pc_q;
                        state_d   = S_VALID;
                    end
                end
`ifdef IFU_TIMEOUT_EN
                if (!mem_rvalid) begin
                    cnt_d = w_cnt_inc;
                    if (!redirect_valid && (w_cnt_inc == TIMEOUT)) begin
                        state_d = S_ERR;
                        err_d   = 1'b1;
                    end
                end
`endif
            end
            S_VALID: begin
                if (redirect_valid) begin
                    state_d = S_REQ;
                end else if (inst_ready) begin
                    pc_d    = next_pc[31:2];
                    state_d = S_REQ;
                end
            end
`ifdef IFU_TIMEOUT_EN
            S_ERR: state_d = S_ERR;
`endif
            default: state_d = S_IDLE;
        endcase
        if (redirect_valid) begin
            pc_d = redirect_pc[31:2];
        end
    end

    assign mem_req    = (state_q == S_REQ);
    assign mem_addr   = {pc_q, 2'b00};
    assign inst_valid = (state_q == S_VALID);
    assign inst       = inst_q;
    assign inst_pc    = {inst_pc_q, 2'b00};
`ifdef IFU_TIMEOUT_EN
    assign fetch_err  = err_q;
`else
    assign fetch_err  = 1'b0;
`endif

endmodule

`default_nettype wire
